// File: rtl/button_input_pkg.sv
// Shared game definitions used by the button input path: state/arrow encodings
// and the chord FSM state type.
package button_input_pkg;

  localparam int STATE_BITS      = 2;
  localparam int NUM_ARROWS_BITS = 3;

  localparam logic [STATE_BITS:0] STATE_PLAY = 3'd2;

  // Arrow bit positions inside every 4-bit button mask.
  localparam int ARROW_U = 3;
  localparam int ARROW_D = 2;
  localparam int ARROW_L = 1;
  localparam int ARROW_R = 0;

  typedef enum logic [1:0] {
    CHORD_IDLE    = 2'd0,
    CHORD_COLLECT = 2'd1,
    CHORD_EMIT    = 2'd2
  } chord_state_e;

  function automatic logic is_play(input logic [STATE_BITS:0] st);
    return (st == STATE_PLAY);
  endfunction

endpackage

// File: rtl/button_input_if.sv
// Raw buttons and game state in, debounced levels and chord events out.
interface button_input_if;
  import button_input_pkg::*;

  logic                     btnU;
  logic                     btnD;
  logic                     btnL;
  logic                     btnR;
  logic [STATE_BITS:0]      state;
  logic [3:0]               held_mask;
  logic [NUM_ARROWS_BITS:0] press_mask;
  logic                     press_valid;

  modport master (
    output btnU, btnD, btnL, btnR, state,
    input  held_mask, press_mask, press_valid
  );

  modport slave (
    input  btnU, btnD, btnL, btnR, state,
    output held_mask, press_mask, press_valid
  );

endinterface

// File: rtl/button_input_debounce.sv
// Two-flop synchronizer plus stability counter for one button; o_rise is high
// in the cycle whose closing edge moves the stable level from 0 to 1.
module button_input_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DEB_BITS        = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_stable,
  output logic o_rise
);

  localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'(DEBOUNCE_CYCLES - 1);

  logic                r_s1;
  logic                r_s2;
  logic                r_stable;
  logic [DEB_BITS-1:0] r_cnt;
  logic                w_accept;

  assign w_accept = (r_s2 != r_stable) && (r_cnt == DEB_LAST);

  // Synchronize, then count consecutive cycles that disagree with the stable level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= {DEB_BITS{1'b0}};
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= {DEB_BITS{1'b0}};
      end else if (w_accept) begin
        r_stable <= r_s2;
        r_cnt    <= {DEB_BITS{1'b0}};
      end else begin
        r_cnt <= r_cnt + DEB_BITS'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = w_accept & r_s2;

endmodule

// File: rtl/button_input.sv
// Debounces the four arrow buttons and merges presses that land within one
// collection window into a single chord pulse, only while the game is in play.
module button_input
  import button_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DEB_BITS        = 20,
  parameter int CHORD_CYCLES    = 2000000,
  parameter int CHORD_BITS      = 21
) (
  input logic           clk,
  input logic           reset,
  button_input_if.slave btn_if
);

  localparam logic [CHORD_BITS-1:0] CHORD_LAST = CHORD_BITS'(CHORD_CYCLES - 1);

  logic [3:0]               w_raw;
  logic [3:0]               w_stable;
  logic [3:0]               w_ev;
  logic                     w_play;
  logic                     w_emit;
  chord_state_e             r_state;
  chord_state_e             w_state_nxt;
  logic [NUM_ARROWS_BITS:0] r_mask;
  logic [NUM_ARROWS_BITS:0] w_mask_nxt;
  logic [CHORD_BITS-1:0]    r_timer;
  logic [CHORD_BITS-1:0]    w_timer_nxt;

  assign w_raw[ARROW_U] = btn_if.btnU;
  assign w_raw[ARROW_D] = btn_if.btnD;
  assign w_raw[ARROW_L] = btn_if.btnL;
  assign w_raw[ARROW_R] = btn_if.btnR;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    button_input_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DEB_BITS        (DEB_BITS)
    ) u_deb (
      .clk      (clk),
      .rst      (reset),
      .i_btn    (w_raw[g]),
      .o_stable (w_stable[g]),
      .o_rise   (w_ev[g])
    );
  end

  assign w_play = is_play(btn_if.state);

  // Chord state, accumulated mask and window timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CHORD_IDLE;
      r_mask  <= 4'b0000;
      r_timer <= {CHORD_BITS{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state logic; leaving play abandons whatever chord is in progress.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_timer_nxt = r_timer;
    if (!w_play) begin
      w_state_nxt = CHORD_IDLE;
      w_mask_nxt  = 4'b0000;
      w_timer_nxt = {CHORD_BITS{1'b0}};
    end else begin
      case (r_state)
        CHORD_IDLE: begin
          if (w_ev != 4'b0000) begin
            w_state_nxt = CHORD_COLLECT;
            w_mask_nxt  = w_ev;
            w_timer_nxt = {CHORD_BITS{1'b0}};
          end else begin
            w_state_nxt = CHORD_IDLE;
          end
        end
        CHORD_COLLECT: begin
          w_mask_nxt = r_mask | w_ev;
          if (r_timer == CHORD_LAST) begin
            w_state_nxt = CHORD_EMIT;
          end else begin
            w_timer_nxt = r_timer + CHORD_BITS'(1);
          end
        end
        CHORD_EMIT: begin
          // A press landing in the emit cycle opens the next chord immediately.
          if (w_ev != 4'b0000) begin
            w_state_nxt = CHORD_COLLECT;
            w_mask_nxt  = w_ev;
            w_timer_nxt = {CHORD_BITS{1'b0}};
          end else begin
            w_state_nxt = CHORD_IDLE;
            w_mask_nxt  = 4'b0000;
          end
        end
        default: begin
          w_state_nxt = CHORD_IDLE;
          w_mask_nxt  = 4'b0000;
          w_timer_nxt = {CHORD_BITS{1'b0}};
        end
      endcase
    end
  end

  // The pulse is gated by the live game state so a mid-cycle exit from play suppresses it.
  always_comb begin
    w_emit = 1'b0;
    if ((r_state == CHORD_EMIT) && w_play) begin
      w_emit = 1'b1;
    end else begin
      w_emit = 1'b0;
    end
  end

  assign btn_if.press_valid = w_emit;
  assign btn_if.press_mask  = w_emit ? r_mask : 4'b0000;
  assign btn_if.held_mask   = w_stable;

endmodule

// File: tb/tb_button_input.sv
// Bench for button_input with short debounce/chord windows: vector table,
// directed corner sequences and random stimulus against a window-based model.
module tb_button_input;
  import button_input_pkg::*;

  localparam int DEB = 4;
  localparam int CH  = 3;
  localparam logic [STATE_BITS:0] ST_MENU = 3'd1;

  logic clk = 1'b0;
  logic reset;
  button_input_if bif ();

  button_input #(
    .DEBOUNCE_CYCLES (DEB),
    .DEB_BITS        (3),
    .CHORD_CYCLES    (CH),
    .CHORD_BITS      (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_if (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulse  = 0;
  logic [3:0] last_pm = 4'b0000;

  logic [3:0]          cur_btn;
  logic [STATE_BITS:0] cur_state;

  // Reference model: per-button sample history, last-accept time, chord window.
  logic [3:0] m_stable;
  int         m_last[4];
  logic       m_hist[4][$];
  int         cyc;
  bit         m_open;
  int         m_start;
  logic [3:0] m_mask;

  typedef struct {
    logic [3:0] btns;
    int         hold;
    int         exp_pulses;
    logic [3:0] exp_pmask;
    logic [3:0] exp_held;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [3:0] b, input logic [STATE_BITS:0] st);
    cur_btn   = b;
    cur_state = st;
    bif.btnU  = b[3];
    bif.btnD  = b[2];
    bif.btnL  = b[1];
    bif.btnR  = b[0];
    bif.state = st;
  endtask

  task automatic model_reset();
    m_stable = 4'b0000;
    cyc      = 0;
    m_open   = 1'b0;
    m_start  = 0;
    m_mask   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_last[i] = -1000;
      m_hist[i].delete();
      for (int j = 0; j < DEB + 3; j++) m_hist[i].push_back(1'b0);
    end
  endtask

  // A level is accepted once the last DEB synchronized samples (two edges old)
  // all disagree with it and at least DEB edges have passed since the previous accept.
  task automatic model_edge();
    logic [3:0] ev;
    bit         all_diff;
    int         sz;
    ev = 4'b0000;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      m_hist[i].push_back(cur_btn[i]);
      if (m_hist[i].size() > DEB + 3) void'(m_hist[i].pop_front());
      sz = m_hist[i].size();
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (m_hist[i][sz - 3 - j] == m_stable[i]) all_diff = 1'b0;
      if (all_diff && (cyc - m_last[i] >= DEB)) begin
        m_stable[i] = !m_stable[i];
        m_last[i]   = cyc;
        if (m_stable[i]) ev[i] = 1'b1;
      end
    end
    if (cur_state != STATE_PLAY) begin
      m_open = 1'b0;
    end else begin
      if (m_open && (cyc > m_start + CH)) m_open = 1'b0;
      if (ev != 4'b0000) begin
        if (m_open) m_mask = m_mask | ev;
        else begin
          m_open  = 1'b1;
          m_start = cyc;
          m_mask  = ev;
        end
      end
    end
  endtask

  task automatic cmp_model();
    logic       ev_v;
    logic [3:0] ev_m;
    ev_v = m_open && (cyc == m_start + CH) && (cur_state == STATE_PLAY);
    ev_m = ev_v ? m_mask : 4'b0000;
    chk("model_valid", 32'(bif.press_valid), 32'(ev_v));
    chk("model_pmask", 32'(bif.press_mask), 32'(ev_m));
    chk("model_held", 32'(bif.held_mask), 32'(m_stable));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_model();
    if (bif.press_valid) begin
      n_pulse++;
      last_pm = bif.press_mask;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bif.press_valid), 32'(1'b0));
    chk("reset_pmask", 32'(bif.press_mask), 32'(4'b0000));
    chk("reset_held", 32'(bif.held_mask), 32'(4'b0000));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic settle(input int n);
    set_in(4'b0000, STATE_PLAY);
    repeat (n) step();
    n_pulse = 0;
    last_pm = 4'b0000;
  endtask

  initial begin
    set_in(4'b0000, STATE_PLAY);
    apply_reset();
    settle(3);

    // Single press held: pulse only after edge 9, level visible from edge 6.
    set_in(4'b1000, STATE_PLAY);
    for (int e = 1; e <= 14; e++) begin
      step();
      chk("single_valid", 32'(bif.press_valid), 32'(e == 9));
      if (e == 9) chk("single_pmask", 32'(bif.press_mask), 32'(4'b1000));
      if (e == 5) chk("single_held_pre", 32'(bif.held_mask), 32'(4'b0000));
      if (e == 6) chk("single_held", 32'(bif.held_mask), 32'(4'b1000));
    end
    n_pulse = 0;
    repeat (20) step();
    chk("single_no_repeat", 32'(n_pulse), 32'(0));
    settle(15);

    // Glitch of three cycles on L.
    set_in(4'b0010, STATE_PLAY);
    repeat (3) step();
    set_in(4'b0000, STATE_PLAY);
    repeat (15) begin
      step();
      chk("glitch_held", 32'(bif.held_mask), 32'(4'b0000));
    end
    chk("glitch_pulses", 32'(n_pulse), 32'(0));
    settle(5);

    // Chord: L at edge 1, R at edge 3.
    set_in(4'b0010, STATE_PLAY);
    repeat (2) step();
    set_in(4'b0011, STATE_PLAY);
    repeat (20) step();
    chk("chord_pulses", 32'(n_pulse), 32'(1));
    chk("chord_pmask", 32'(last_pm), 32'(4'b0011));
    settle(15);

    // Back-to-back: D becomes stable in the emit cycle of the U chord.
    for (int e = 1; e <= 18; e++) begin
      if (e == 1) set_in(4'b1000, STATE_PLAY);
      if (e == 5) set_in(4'b1100, STATE_PLAY);
      step();
      chk("b2b_valid", 32'(bif.press_valid), 32'((e == 9) || (e == 13)));
      if (e == 9)  chk("b2b_pmask1", 32'(bif.press_mask), 32'(4'b1000));
      if (e == 13) chk("b2b_pmask2", 32'(bif.press_mask), 32'(4'b0100));
    end
    settle(15);

    // Gating: press outside play, enter play still held, then re-press.
    set_in(4'b1000, ST_MENU);
    repeat (10) step();
    chk("gate_held", 32'(bif.held_mask), 32'(4'b1000));
    set_in(4'b1000, STATE_PLAY);
    repeat (15) step();
    chk("gate_no_pulse", 32'(n_pulse), 32'(0));
    set_in(4'b0000, STATE_PLAY);
    repeat (10) step();
    set_in(4'b1000, STATE_PLAY);
    repeat (15) step();
    chk("gate_repress_pulses", 32'(n_pulse), 32'(1));
    chk("gate_repress_pmask", 32'(last_pm), 32'(4'b1000));
    settle(15);

    // Reset asserted during COLLECT.
    set_in(4'b1000, STATE_PLAY);
    repeat (7) step();
    #2;
    reset = 1'b1;
    set_in(4'b0000, STATE_PLAY);
    model_reset();
    #1;
    chk("areset_valid", 32'(bif.press_valid), 32'(1'b0));
    chk("areset_pmask", 32'(bif.press_mask), 32'(4'b0000));
    chk("areset_held", 32'(bif.held_mask), 32'(4'b0000));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n_pulse = 0;
    repeat (15) step();
    chk("areset_no_pulse", 32'(n_pulse), 32'(0));
    settle(5);

    // Vector table: press pattern, hold length, pulse count, pulse mask, level after hold+2 edges.
    vecs[0] = '{4'b1000, 3,  0, 4'b0000, 4'b0000};
    vecs[1] = '{4'b1000, 4,  1, 4'b1000, 4'b1000};
    vecs[2] = '{4'b0011, 10, 1, 4'b0011, 4'b0011};
    vecs[3] = '{4'b1111, 6,  1, 4'b1111, 4'b1111};
    vecs[4] = '{4'b0100, 2,  0, 4'b0000, 4'b0000};
    vecs[5] = '{4'b0000, 5,  0, 4'b0000, 4'b0000};
    vecs[6] = '{4'b0001, 30, 1, 4'b0001, 4'b0001};
    for (int v = 0; v < 7; v++) begin
      n_pulse = 0;
      last_pm = 4'b0000;
      set_in(vecs[v].btns, STATE_PLAY);
      for (int e = 1; e <= vecs[v].hold + 22; e++) begin
        if (e == vecs[v].hold + 1) set_in(4'b0000, STATE_PLAY);
        step();
        if (e == vecs[v].hold + 2) chk("vec_held", 32'(bif.held_mask), 32'(vecs[v].exp_held));
      end
      chk("vec_pulses", 32'(n_pulse), 32'(vecs[v].exp_pulses));
      chk("vec_pmask", 32'(last_pm), 32'(vecs[v].exp_pmask));
    end

    // Random toggling of buttons and occasional exits from play.
    for (int c = 0; c < 4000; c++) begin
      logic [3:0]          nb;
      logic [STATE_BITS:0] ns;
      nb = cur_btn;
      ns = cur_state;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) nb[i] = ~nb[i];
      if (ns == STATE_PLAY) begin
        if ($urandom_range(0, 79) == 0) ns = ST_MENU;
      end else begin
        if ($urandom_range(0, 9) == 0) ns = STATE_PLAY;
      end
      set_in(nb, ns);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
